// File: rtl/skel_pkg.sv
// Shared types and constants for the skeletonization write-back path.
package skel_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    REPORT  = 2'd2,
    REPLAY  = 2'd3
  } wb_state_t;

  // Each replayed pixel is held this many cycles for the half-rate consumer.
  localparam int unsigned REPLAY_HOLD = 2;

  function automatic int unsigned addr_width(input int unsigned bit_size);
    return bit_size + 1;
  endfunction

endpackage

// File: rtl/wb_frame_buf.sv
// Frame buffer: async-read / sync-write pixel store plus a per-entry valid
// bitmap that is cleared by reset (storage itself is not).
module wb_frame_buf #(
  parameter int unsigned DEPTH = 64,
  parameter int unsigned IW    = 6,
  parameter int unsigned PW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [IW-1:0] waddr,
  input  logic [PW-1:0] wdata,
  input  logic [IW-1:0] cap_addr,
  output logic [PW-1:0] cap_data_c,
  output logic          cap_valid_c,
  input  logic [IW-1:0] rep_addr,
  output logic [PW-1:0] rep_data_c
);

  logic [PW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] valid;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  valid        <= '0;
    else if (we) valid[waddr] <= 1'b1;
  end

  assign cap_data_c  = mem[cap_addr];
  assign cap_valid_c = valid[cap_addr];
  assign rep_data_c  = mem[rep_addr];

endmodule

// File: rtl/mask_writeback.sv
// Captures the convolution write-out stream, counts changed pixels per pass and
// replays the frame as a load stream. Optional Harris map: HARRIS_MAP_EN.
module mask_writeback
  import skel_pkg::*;
#(
  parameter int unsigned N          = 8,
  parameter int unsigned bitSize    = 6,
  parameter int unsigned pixelWidth = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wo_en,
  input  logic [bitSize:0]      wo_addr,
  input  logic [pixelWidth-1:0] wo_pixel,
  input  logic                  wo_harris,
  input  logic                  start_replay,
  output logic                  ld_we,
  output logic [pixelWidth-1:0] ld_data,
  output logic                  pass_done,
  output logic                  converged,
  output logic [bitSize+1:0]    change_count,
  output logic                  busy,
  output logic [bitSize+1:0]    corner_count
);

  localparam int unsigned AW   = addr_width(bitSize);
  localparam int unsigned AW1  = AW + 1;
  localparam int unsigned CW   = bitSize + 2;
  localparam int unsigned NPIX = N * N;
  localparam int unsigned IW   = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam int unsigned RLEN = REPLAY_HOLD * NPIX;

  wb_state_t             state, state_d;
  logic                  prev_wo_en;
  logic [AW-1:0]         last_addr, last_addr_d;
  logic [CW-1:0]         chg_cnt, chg_cnt_d, crn_cnt, crn_cnt_d;
  logic [CW-1:0]         rep_cnt, rep_cnt_d, rep_next_c;
  logic                  ld_we_d, pass_done_d, converged_d, busy_d;
  logic [pixelWidth-1:0] ld_data_d;
  logic [CW-1:0]         change_count_d, corner_count_d;

  logic                  rise_c, in_range_c, take_c, wr_c, diff_c;
  logic [IW-1:0]         wr_idx_c, rep_idx_c;
  logic [pixelWidth-1:0] cap_data_c, rep_data_c;
  logic                  cap_valid_c;

  assign rise_c     = wo_en && !prev_wo_en;
  assign in_range_c = {1'b0, wo_addr} < AW1'(NPIX);
  assign take_c     = wo_en && (((state == IDLE) && rise_c) ||
                                ((state == CAPTURE) && (wo_addr != last_addr)));
  assign wr_c       = take_c && in_range_c;
  assign wr_idx_c   = IW'(wo_addr);
  assign diff_c     = !cap_valid_c || (cap_data_c != wo_pixel);
  assign rep_next_c = (state == REPLAY) ? rep_cnt + CW'(1) : '0;
  assign rep_idx_c  = IW'(rep_next_c / CW'(REPLAY_HOLD));

  wb_frame_buf #(
    .DEPTH(NPIX),
    .IW   (IW),
    .PW   (pixelWidth)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (wr_c),
    .waddr      (wr_idx_c),
    .wdata      (wo_pixel),
    .cap_addr   (wr_idx_c),
    .cap_data_c (cap_data_c),
    .cap_valid_c(cap_valid_c),
    .rep_addr   (rep_idx_c),
    .rep_data_c (rep_data_c)
  );

`ifdef HARRIS_MAP_EN
  logic [NPIX-1:0] harris_map;

  always_ff @(posedge clk) begin
    if (wr_c) harris_map[wr_idx_c] <= wo_harris;
  end
`else
  logic harris_unused;
  assign harris_unused = wo_harris;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d        = state;
    last_addr_d    = take_c ? wo_addr : last_addr;
    chg_cnt_d      = chg_cnt + ((wr_c && diff_c) ? CW'(1) : CW'(0));
`ifdef HARRIS_MAP_EN
    crn_cnt_d      = crn_cnt + ((wr_c && wo_harris) ? CW'(1) : CW'(0));
`else
    crn_cnt_d      = '0;
`endif
    rep_cnt_d      = rep_cnt;
    ld_we_d        = 1'b0;
    ld_data_d      = ld_data;
    pass_done_d    = 1'b0;
    converged_d    = converged;
    change_count_d = change_count;
    corner_count_d = corner_count;

    case (state)
      IDLE: begin
        if (rise_c) begin
          state_d = CAPTURE;
        end else if (start_replay && !converged) begin
          state_d   = REPLAY;
          rep_cnt_d = '0;
          ld_we_d   = 1'b1;
          ld_data_d = rep_data_c;
        end
      end
      CAPTURE: begin
        if (!wo_en) begin
          state_d        = REPORT;
          pass_done_d    = 1'b1;
          change_count_d = chg_cnt;
          corner_count_d = crn_cnt;
          converged_d    = (chg_cnt == '0);
          chg_cnt_d      = '0;
          crn_cnt_d      = '0;
        end
      end
      REPORT: state_d = IDLE;
      REPLAY: begin
        if (rep_cnt == CW'(RLEN - 1)) begin
          state_d = IDLE;
        end else begin
          rep_cnt_d = rep_next_c;
          ld_we_d   = 1'b1;
          ld_data_d = rep_data_c;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CAPTURE) || (state_d == REPLAY);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      prev_wo_en   <= 1'b0;
      last_addr    <= '0;
      chg_cnt      <= '0;
      crn_cnt      <= '0;
      rep_cnt      <= '0;
      ld_we        <= 1'b0;
      ld_data      <= '0;
      pass_done    <= 1'b0;
      converged    <= 1'b0;
      change_count <= '0;
      corner_count <= '0;
      busy         <= 1'b0;
    end else begin
      state        <= state_d;
      prev_wo_en   <= wo_en;
      last_addr    <= last_addr_d;
      chg_cnt      <= chg_cnt_d;
      crn_cnt      <= crn_cnt_d;
      rep_cnt      <= rep_cnt_d;
      ld_we        <= ld_we_d;
      ld_data      <= ld_data_d;
      pass_done    <= pass_done_d;
      converged    <= converged_d;
      change_count <= change_count_d;
      corner_count <= corner_count_d;
      busy         <= busy_d;
    end
  end

endmodule

// File: tb/tb_mask_writeback.sv
// Directed bench for mask_writeback with a frame-level reference model.
module tb_mask_writeback;

  localparam int NP = 64;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wo_en = 1'b0;
  logic [6:0] wo_addr = '0;
  logic [7:0] wo_pixel = '0;
  logic       wo_harris = 1'b0;
  logic       start_replay = 1'b0;
  logic       ld_we, pass_done, converged, busy;
  logic [7:0] ld_data, change_count, corner_count;

  mask_writeback #(.N(8), .bitSize(6), .pixelWidth(8)) dut (
    .clk(clk), .rst_n(rst_n), .wo_en(wo_en), .wo_addr(wo_addr),
    .wo_pixel(wo_pixel), .wo_harris(wo_harris), .start_replay(start_replay),
    .ld_we(ld_we), .ld_data(ld_data), .pass_done(pass_done),
    .converged(converged), .change_count(change_count), .busy(busy),
    .corner_count(corner_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference frame model and expected outputs.
  logic [7:0] img  [NP];
  logic       hmap [NP];
  logic [7:0] mbuf [NP];
  logic       mvalid [NP];
  int         mcnt = 0, mcrn = 0;
  logic       exp_busy = 0, exp_ld_we = 0, exp_pass_done = 0, exp_conv = 0;
  logic [7:0] exp_ld_data = 0, exp_change = 0, exp_corner = 0;
  bit         chk_en = 0;
  int         we_cycles = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", int'(busy), int'(exp_busy));
      check("ld_we", int'(ld_we), int'(exp_ld_we));
      check("pass_done", int'(pass_done), int'(exp_pass_done));
      check("converged", int'(converged), int'(exp_conv));
      check("change_count", int'(change_count), int'(exp_change));
      check("corner_count", int'(corner_count), int'(exp_corner));
      if (exp_ld_we) check("ld_data", int'(ld_data), int'(exp_ld_data));
      if (ld_we) we_cycles++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [6:0] a, input logic [7:0] p, input logic h);
    wo_en = en; wo_addr = a; wo_pixel = p; wo_harris = h;
  endtask

  task automatic model_sample(input int k);
    if (!mvalid[k] || mbuf[k] != img[k]) mcnt++;
`ifdef HARRIS_MAP_EN
    if (hmap[k]) mcrn++;
`endif
    mbuf[k] = img[k];
    mvalid[k] = 1'b1;
  endtask

  // Streams addresses 0..stop_at-1 (each held 2 cycles); full passes end with a report.
  task automatic run_pass(input int stop_at, input bit inject);
    for (int k = 0; k < NP; k++) begin
      if (k == stop_at) return;
      if (inject && k == 32) begin
        for (int r = 0; r < 2; r++) begin
          drive(1'b1, 7'd70, 8'hA5, 1'b1); step(); exp_busy = 1;
        end
      end
      model_sample(k);
      for (int r = 0; r < 2; r++) begin
        drive(1'b1, 7'(k), img[k], hmap[k]); step(); exp_busy = 1;
      end
    end
    drive(1'b0, 7'd0, 8'd0, 1'b0);
    step();
    exp_busy = 0; exp_pass_done = 1;
    exp_change = 8'(mcnt); exp_corner = 8'(mcrn); exp_conv = (mcnt == 0);
    mcnt = 0; mcrn = 0;
    step();
    exp_pass_done = 0;
  endtask

  task automatic run_replay(input bit expect_run);
    we_cycles = 0;
    start_replay = 1'b1;
    step();
    start_replay = 1'b0;
    if (!expect_run) begin
      repeat (4) step();
      check("replay_ignored_we_cycles", we_cycles, 0);
      return;
    end
    for (int c = 0; c < 2 * NP; c++) begin
      if (c > 0) step();
      exp_ld_we = 1; exp_busy = 1; exp_ld_data = mbuf[c / 2];
    end
    step();
    exp_ld_we = 0; exp_busy = 0;
    step();
    check("replay_we_cycles", we_cycles, 128);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < NP; k++) begin
      img[k] = 8'h00; hmap[k] = 1'b0; mbuf[k] = 8'h00; mvalid[k] = 1'b0;
    end
    #12;
    check("reset_busy", int'(busy), 0);
    check("reset_ld_we", int'(ld_we), 0);
    check("reset_change_count", int'(change_count), 0);
    check("reset_converged", int'(converged), 0);
    rst_n = 1'b1;
    step();
    chk_en = 1;

    // Pass 1: all zero, every entry invalid -> 64 changes; 5 Harris corners.
    hmap[3] = 1; hmap[9] = 1; hmap[20] = 1; hmap[41] = 1; hmap[63] = 1;
    run_pass(NP, 0);
    check("p1_change_lit", int'(change_count), 64);
    check("p1_conv_lit", int'(converged), 0);
`ifdef HARRIS_MAP_EN
    check("p1_corner_lit", int'(corner_count), 5);
`else
    check("p1_corner_lit", int'(corner_count), 0);
`endif
    for (int k = 0; k < NP; k++) hmap[k] = 1'b0;

    // Pass 2: identical frame -> converged, replay request ignored.
    run_pass(NP, 0);
    check("p2_change_lit", int'(change_count), 0);
    check("p2_conv_lit", int'(converged), 1);
    run_replay(0);

    // Pass 3: two pixels changed plus an out-of-range address mid-stream.
    img[10] = 8'hFF; img[37] = 8'h5A;
    run_pass(NP, 1);
    check("p3_change_lit", int'(change_count), 2);
    check("p3_conv_lit", int'(converged), 0);
    run_replay(1);

    // Pass 4: ramp pattern, replayed.
    for (int k = 0; k < NP; k++) img[k] = 8'(k * 3);
    run_pass(NP, 0);
    check("p4_change_lit", int'(change_count), 63);
    run_replay(1);

    // Reset partway through a capture.
    run_pass(30, 0);
    exp_busy = 0; exp_ld_we = 0; exp_pass_done = 0; exp_conv = 0;
    exp_change = 0; exp_corner = 0;
    #2 rst_n = 1'b0;
    #1;
    check("midrst_busy", int'(busy), 0);
    check("midrst_change", int'(change_count), 0);
    check("midrst_conv", int'(converged), 0);
    check("midrst_pass_done", int'(pass_done), 0);
    for (int k = 0; k < NP; k++) mvalid[k] = 1'b0;
    mcnt = 0; mcrn = 0;
    drive(1'b0, 7'd0, 8'd0, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    run_pass(NP, 0);
    check("post_rst_change_lit", int'(change_count), 64);

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
